// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode encodings, control states and latency helper for seq_alu
package seq_alu_pkg;
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_NOR   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_LUI   = 4'b0101;
  localparam logic [3:0] OP_JAL   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;
  localparam logic [3:0] OP_SRL   = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_SLL   = 4'b1110;
  localparam logic [3:0] OP_XOR   = 4'b1111;
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;
  function automatic int DONE_LAT(input int data_width);
    return data_width + 1;
  endfunction
endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: operation request and result bundle between control unit and seq_alu
interface seq_alu_if #(parameter int DATA_WIDTH = 32, parameter int SHAMT_WIDTH = 5);
  logic                   start;
  logic [3:0]             ALUOperation;
  logic [DATA_WIDTH-1:0]  A;
  logic [DATA_WIDTH-1:0]  B;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   busy;
  logic                   done;
  logic [DATA_WIDTH-1:0]  ALUResult;
  logic                   Zero;
  logic                   Overflow;
  logic [DATA_WIDTH-1:0]  HI;
  logic [DATA_WIDTH-1:0]  LO;
  modport master (output start, ALUOperation, A, B, shamt,
                  input busy, done, ALUResult, Zero, Overflow, HI, LO);
  modport slave  (input start, ALUOperation, A, B, shamt,
                  output busy, done, ALUResult, Zero, Overflow, HI, LO);
endinterface

// File: rtl/seq_alu_muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle unsigned shift-add multiply / restoring divide
module muldiv_iter #(parameter int DATA_WIDTH = 32) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go_i,
  input  logic                  mul_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  finished_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  logic [W-1:0]  hi_q, lo_q, opnd_q, hi_d, lo_d;
  logic [CW-1:0] cnt_q;
  logic          mul_q, act_q;
  logic [W:0]    r_sh;
  logic [W+1:0]  x, y, s;
  // shared adder: multiply adds the multiplicand when the low bit is set,
  // divide subtracts the divisor from the shifted partial remainder (s[W+1] = borrow)
  always_comb begin
    r_sh = {hi_q, lo_q[W-1]};
    x    = mul_q ? {2'b0, hi_q} : {1'b0, r_sh};
    y    = mul_q ? (lo_q[0] ? {2'b0, opnd_q} : '0) : ~{2'b0, opnd_q};
    s    = x + y + {{(W+1){1'b0}}, !mul_q};
    hi_d = mul_q ? s[W:1] : (s[W+1] ? r_sh[W-1:0] : s[W-1:0]);
    lo_d = mul_q ? {s[0], lo_q[W-1:1]} : {lo_q[W-2:0], !s[W+1]};
  end
  assign finished_o = act_q && cnt_q == CW'(W - 1);
  assign hi_o       = hi_d;
  assign lo_o       = lo_d;
  // operand load on go, then one iteration per cycle until the last bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      mul_q  <= 1'b0;
      act_q  <= 1'b0;
    end else if (go_i) begin
      hi_q   <= '0;
      lo_q   <= mul_i ? b_i : a_i;
      opnd_q <= mul_i ? a_i : b_i;
      cnt_q  <= '0;
      mul_q  <= mul_i;
      act_q  <= 1'b1;
    end else if (act_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CW'(1);
      act_q <= !finished_o;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with iterative MULTU/DIVU and start/busy/done handshake
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5,
  parameter bit MULDIV_EN   = 1'b1
) (
  input logic     clk,
  input logic     reset,
  seq_alu_if.slave bus
);
  localparam int W = DATA_WIDTH;
  state_e       state_q, state_d;
  logic [W-1:0] res_q, hi_q, lo_q, res_c, sum, dif, md_hi, md_lo;
  logic         zero_q, ovf_q, done_q, ovf_c, md_op, accept, go, fin;
  assign md_op  = MULDIV_EN && (bus.ALUOperation == OP_MULTU || bus.ALUOperation == OP_DIVU);
  assign accept = state_q == IDLE && bus.start;
  assign go     = accept && md_op;
  assign sum    = bus.A + bus.B;
  assign dif    = bus.A - bus.B;
  // single-cycle result and overflow; MULTU/DIVU land in default (result 0) when not iterated
  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    case (bus.ALUOperation)
      OP_AND:  res_c = bus.A & bus.B;
      OP_OR:   res_c = bus.A | bus.B;
      OP_NOR:  res_c = ~(bus.A | bus.B);
      OP_ADD:  begin
        res_c = sum;
        ovf_c = bus.A[W-1] == bus.B[W-1] && sum[W-1] != bus.A[W-1];
      end
      OP_SUB:  begin
        res_c = dif;
        ovf_c = bus.A[W-1] != bus.B[W-1] && dif[W-1] != bus.A[W-1];
      end
      OP_LUI:  res_c = W'(bus.B[15:0]) << (W - 16);
      OP_JAL:  res_c = bus.B;
      OP_SLT:  res_c = {{(W-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      OP_MFHI: res_c = hi_q;
      OP_MFLO: res_c = lo_q;
      OP_SRL:  res_c = bus.B >> bus.shamt;
      OP_SRA:  res_c = $unsigned($signed(bus.B) >>> bus.shamt);
      OP_SLL:  res_c = bus.B << bus.shamt;
      OP_XOR:  res_c = bus.A ^ bus.B;
      default: res_c = '0;
    endcase
  end
  generate
    if (MULDIV_EN) begin : g_md
      muldiv_iter #(.DATA_WIDTH(W)) u_iter (
        .clk(clk), .reset(reset), .go_i(go), .mul_i(bus.ALUOperation == OP_MULTU),
        .a_i(bus.A), .b_i(bus.B), .finished_o(fin), .hi_o(md_hi), .lo_o(md_lo)
      );
    end else begin : g_no_md
      assign fin   = 1'b0;
      assign md_hi = '0;
      assign md_lo = '0;
    end
  endgenerate
  // control FSM next state: leave IDLE only for an iterated op, return when it finishes
  always_comb begin
    state_d = state_q == IDLE ? (go ? (bus.ALUOperation == OP_MULTU ? MUL : DIV) : IDLE)
                              : (fin ? IDLE : state_q);
  end
  // state, result registers and HI/LO; results hold between operations
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (accept && !md_op) || fin;
      if (accept && !md_op) begin
        res_q  <= res_c;
        zero_q <= res_c == '0;
        ovf_q  <= ovf_c;
      end else if (fin) begin
        res_q  <= md_lo;
        zero_q <= md_lo == '0;
        ovf_q  <= 1'b0;
        hi_q   <= md_hi;
        lo_q   <= md_lo;
      end
    end
  end
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = done_q;
  assign bus.ALUResult = res_q;
  assign bus.Zero      = zero_q;
  assign bus.Overflow  = ovf_q;
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;
endmodule
